// File: rtl/avaliador_polinomio_pkg.sv
// Shared types and helpers for the Horner polynomial evaluator.
// Holds the control state encoding, the run-time degree clamp and the degree-width helper.
package avaliador_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        CARREGA,
        MULT,
        SOMA,
        FIM
    } estado_t;

    // Width of the grau port: max(1, clog2(deg+1)).
    function automatic int grau_width(input int deg);
        return (deg + 1 > 2) ? $clog2(deg + 1) : 1;
    endfunction

    function automatic int clamp_grau(input int g, input int max_deg);
        return (g > max_deg) ? max_deg : g;
    endfunction

endpackage

// File: rtl/avaliador_polinomio_if.sv
// Start/operand/result bundle of the polynomial evaluator.
// The sequencer or bench drives it through master; the evaluator uses slave.
interface avaliador_polinomio_if #(
    parameter int XW  = 8,
    parameter int DW  = 16,
    parameter int DEG = 2
) ();
    import avaliador_pkg::*;

    localparam int GW = grau_width(DEG);

    logic                  inicio;
    logic [XW-1:0]         X;
    logic [(DEG+1)*DW-1:0] coef;
    logic [GW-1:0]         grau;
    logic [DW-1:0]         resultado;
    logic                  estouro;
    logic                  pronto;
    logic                  comecou;

    modport master (
        output inicio, X, coef, grau,
        input  resultado, estouro, pronto, comecou
    );

    modport slave (
        input  inicio, X, coef, grau,
        output resultado, estouro, pronto, comecou
    );

endinterface

// File: rtl/avaliador_operativo.sv
// Datapath of the evaluator: operand registers, Horner accumulator, multiplier,
// adder, coefficient select and the sticky overflow flag.
module avaliador_operativo
    import avaliador_pkg::*;
#(
    parameter int XW  = 8,
    parameter int DW  = 16,
    parameter int DEG = 2,
    parameter int GW  = grau_width(DEG)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ld_op,
    input  logic                  ld_acc,
    input  logic                  ld_prod,
    input  logic                  ld_soma,
    input  logic                  ld_res,
    input  logic [XW-1:0]         x_in,
    input  logic [(DEG+1)*DW-1:0] coef_in,
    input  logic [GW-1:0]         grau_in,
    output logic                  g_zero,
    output logic                  idx_um,
    output logic [DW-1:0]         resultado,
    output logic                  estouro
);

    logic [XW-1:0]         x_reg;
    logic [(DEG+1)*DW-1:0] coef_reg;
    logic [GW-1:0]         g_reg;
    logic [GW-1:0]         idx;
    logic [GW-1:0]         sel_idx;
    logic [DW-1:0]         acc;
    logic [DW+XW-1:0]      prod;
    logic [DW+XW-1:0]      prod_full;
    logic [DW-1:0]         coef_sel;
    logic [DW:0]           soma_full;
    logic [DW-1:0]         acc_nxt;
    logic                  ovf;
    logic                  ovf_nxt;

    // CARREGA picks the leading coefficient; SOMA picks the next lower one.
    assign sel_idx = ld_acc ? g_reg : idx - GW'(1);

    always_comb begin
        coef_sel = '0;
        for (int k = 0; k <= DEG; k++) begin
            if (int'(sel_idx) == k) coef_sel = coef_reg[k*DW +: DW];
        end
    end

    assign prod_full = (DW+XW)'(acc) * (DW+XW)'(x_reg);
    assign soma_full = {1'b0, prod[DW-1:0]} + {1'b0, coef_sel};

    // Result registers take the value the accumulator is about to hold, so they
    // are valid in the FIM cycle whichever state leads there.
    assign acc_nxt = ld_acc ? coef_sel : soma_full[DW-1:0];
    assign ovf_nxt = ovf | (ld_soma & soma_full[DW]);

    assign g_zero = (g_reg == '0);
    assign idx_um = (idx == GW'(1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            x_reg     <= '0;
            coef_reg  <= '0;
            g_reg     <= '0;
            idx       <= '0;
            acc       <= '0;
            prod      <= '0;
            ovf       <= 1'b0;
            resultado <= '0;
            estouro   <= 1'b0;
        end else begin
            if (ld_op) begin
                x_reg    <= x_in;
                coef_reg <= coef_in;
                g_reg    <= grau_in;
                ovf      <= 1'b0;
            end
            if (ld_acc) begin
                acc <= coef_sel;
                idx <= g_reg;
            end
            if (ld_prod) begin
                prod <= prod_full;
                if (|prod_full[DW+XW-1:DW]) ovf <= 1'b1;
            end
            if (ld_soma) begin
                acc <= soma_full[DW-1:0];
                idx <= idx - GW'(1);
                if (soma_full[DW]) ovf <= 1'b1;
            end
            if (ld_res) begin
                resultado <= acc_nxt;
                estouro   <= ovf_nxt;
            end
        end
    end

endmodule

// File: rtl/avaliador_polinomio.sv
// Multi-cycle unsigned polynomial evaluator (Horner): control FSM and handshake,
// driving the avaliador_operativo datapath through load strobes.
module avaliador_polinomio
    import avaliador_pkg::*;
#(
    parameter int XW  = 8,
    parameter int DW  = 16,
    parameter int DEG = 2
) (
    input logic                 clk,
    input logic                 reset,
    avaliador_polinomio_if.slave bus
);

    localparam int GW = grau_width(DEG);

    estado_t       estado;
    logic          comecou;
    logic          pronto;
    logic [GW-1:0] grau_c;
    logic          ld_op;
    logic          ld_acc;
    logic          ld_prod;
    logic          ld_soma;
    logic          ld_res;
    logic          g_zero;
    logic          idx_um;
    logic [DW-1:0] resultado;
    logic          estouro;

    assign grau_c = GW'(clamp_grau(int'(bus.grau), DEG));

    assign ld_op   = (estado == OCIOSO) && bus.inicio;
    assign ld_acc  = (estado == CARREGA);
    assign ld_prod = (estado == MULT);
    assign ld_soma = (estado == SOMA);
    assign ld_res  = (ld_acc && g_zero) || (ld_soma && idx_um);

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado  <= OCIOSO;
            comecou <= 1'b0;
            pronto  <= 1'b0;
        end else begin
            comecou <= 1'b0;
            pronto  <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (bus.inicio) begin
                        estado  <= CARREGA;
                        comecou <= 1'b1;
                    end
                end
                CARREGA: begin
                    if (g_zero) begin
                        estado <= FIM;
                        pronto <= 1'b1;
                    end else begin
                        estado <= MULT;
                    end
                end
                MULT: estado <= SOMA;
                SOMA: begin
                    if (idx_um) begin
                        estado <= FIM;
                        pronto <= 1'b1;
                    end else begin
                        estado <= MULT;
                    end
                end
                FIM:     estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

    avaliador_operativo #(
        .XW (XW),
        .DW (DW),
        .DEG(DEG),
        .GW (GW)
    ) u_operativo (
        .clk      (clk),
        .reset    (reset),
        .ld_op    (ld_op),
        .ld_acc   (ld_acc),
        .ld_prod  (ld_prod),
        .ld_soma  (ld_soma),
        .ld_res   (ld_res),
        .x_in     (bus.X),
        .coef_in  (bus.coef),
        .grau_in  (grau_c),
        .g_zero   (g_zero),
        .idx_um   (idx_um),
        .resultado(resultado),
        .estouro  (estouro)
    );

    assign bus.resultado = resultado;
    assign bus.estouro   = estouro;
    assign bus.pronto    = pronto;
    assign bus.comecou   = comecou;

endmodule

// File: tb/tb_avaliador_polinomio.sv
// Directed self-checking bench for avaliador_polinomio with hand-computed results.
module tb_avaliador_polinomio;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    int   lat;
    int   npronto;

    avaliador_polinomio_if #(.XW(8), .DW(16), .DEG(2)) bus ();

    avaliador_polinomio #(.XW(8), .DW(16), .DEG(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] x, input logic [15:0] c2,
                                 input logic [15:0] c1, input logic [15:0] c0,
                                 input logic [1:0] g);
        bus.X    = x;
        bus.coef = {c2, c1, c0};
        bus.grau = g;
    endtask

    // One-cycle start, then wait (bounded) for pronto and check latency/result.
    task automatic runEval(input string tag, input int exp_lat,
                           input logic [15:0] exp_res, input logic exp_ovf);
        bus.inicio = 1'b1;
        tick();
        checkOutput({tag, " comecou"}, 32'(bus.comecou), 32'd1);
        bus.inicio = 1'b0;
        lat = 1;
        while (bus.pronto !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " resultado"}, 32'(bus.resultado), 32'(exp_res));
        checkOutput({tag, " estouro"}, 32'(bus.estouro), 32'(exp_ovf));
        tick();
        checkOutput({tag, " pronto pulse"}, 32'(bus.pronto), 32'd0);
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        reset      = 1'b0;
        bus.inicio = 1'b1;
        applyStimulus(8'd3, 16'd2, 16'd5, 16'd7, 2'd2);

        // Reset held with inicio high: nothing starts.
        tick();
        tick();
        checkOutput("reset resultado", 32'(bus.resultado), 32'd0);
        checkOutput("reset estouro", 32'(bus.estouro), 32'd0);
        checkOutput("reset pronto", 32'(bus.pronto), 32'd0);
        checkOutput("reset comecou", 32'(bus.comecou), 32'd0);
        bus.inicio = 1'b0;
        reset      = 1'b1;
        tick();
        checkOutput("idle comecou", 32'(bus.comecou), 32'd0);

        // 2*9 + 5*3 + 7 = 40
        applyStimulus(8'd3, 16'd2, 16'd5, 16'd7, 2'd2);
        runEval("quad", 6, 16'd40, 1'b0);

        applyStimulus(8'd3, 16'd0, 16'd0, 16'h1234, 2'd0);
        runEval("deg0", 2, 16'h1234, 1'b0);

        applyStimulus(8'd3, 16'd2, 16'd5, 16'd7, 2'd3);
        runEval("clamp", 6, 16'd40, 1'b0);

        // 0xFFFF*255 -> 0xFEFF01 (ovf), 0xFF01*255 -> 0xFE01FF
        applyStimulus(8'd255, 16'hFFFF, 16'd0, 16'd0, 2'd2);
        runEval("ovf", 6, 16'h01FF, 1'b1);
        tick();
        tick();
        checkOutput("ovf held resultado", 32'(bus.resultado), 32'h01FF);
        checkOutput("ovf held estouro", 32'(bus.estouro), 32'd1);
        applyStimulus(8'd3, 16'd0, 16'd0, 16'h1234, 2'd0);
        runEval("ovf clear", 2, 16'h1234, 1'b0);

        // Busy: inicio held high, X changed after acceptance.
        applyStimulus(8'd3, 16'd2, 16'd5, 16'd7, 2'd2);
        bus.inicio = 1'b1;
        tick();
        checkOutput("busy comecou", 32'(bus.comecou), 32'd1);
        bus.X = 8'd9;
        lat = 1;
        while (bus.pronto !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("busy latency", 32'(lat), 32'd6);
        checkOutput("busy resultado", 32'(bus.resultado), 32'd40);
        tick();
        checkOutput("busy idle comecou", 32'(bus.comecou), 32'd0);
        tick();
        checkOutput("busy restart comecou", 32'(bus.comecou), 32'd1);
        bus.inicio = 1'b0;
        // Restart latched X=9: 2*81 + 5*9 + 7 = 214
        lat = 1;
        while (bus.pronto !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checkOutput("restart latency", 32'(lat), 32'd6);
        checkOutput("restart resultado", 32'(bus.resultado), 32'd214);
        tick();

        // Reset sampled at edge 3 of a quadratic evaluation.
        applyStimulus(8'd3, 16'd2, 16'd5, 16'd7, 2'd2);
        bus.inicio = 1'b1;
        tick();
        bus.inicio = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("abort resultado", 32'(bus.resultado), 32'd0);
        checkOutput("abort estouro", 32'(bus.estouro), 32'd0);
        checkOutput("abort comecou", 32'(bus.comecou), 32'd0);
        npronto = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.pronto === 1'b1) npronto++;
            tick();
        end
        checkOutput("abort no pronto", 32'(npronto), 32'd0);
        runEval("after abort", 6, 16'd40, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
